// File: rtl/sram_pixel_streamer_pkg.sv
// Shared widths, FSM state encodings and status-word layout for the SRAM pixel streamer.
package sram_pixel_streamer_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int PIX_W_DEF  = 8;

  // Bit set in the mailbox word to mark the status as written.
  localparam int STATUS_VALID_BIT = 31;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_RD_REQ  = 3'd1;
  localparam state_t S_RD_CAP  = 3'd2;
  localparam state_t S_EMIT    = 3'd3;
  localparam state_t S_WR_STAT = 3'd4;
  localparam state_t S_DONE    = 3'd5;

endpackage

// File: rtl/sram_pixel_streamer_word_unpacker.sv
// Holds one SRAM word and hands out its pixels, lowest lane first, over a valid/ready port.
module word_unpacker #(
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              emit,
  input  logic              last_word,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              pix_last,
  output logic              last_accept
);

  localparam int LANES = DATA_W / PIX_W;
  localparam int IDX_W = $clog2(LANES);

  logic [DATA_W-1:0] buffer;
  logic [IDX_W-1:0]  idx;
  logic              last_byte;

  // Handshake: a pixel moves on a rising edge where pix_valid & pix_ready; while
  // pix_ready is low the lane index holds, so pix_data/pix_last stay stable.
  assign last_byte   = (idx == IDX_W'(LANES - 1));
  assign pix_valid   = emit;
  assign pix_data    = emit ? buffer[idx*PIX_W +: PIX_W] : '0;
  assign pix_last    = emit && last_byte && last_word;
  assign last_accept = emit && pix_ready && last_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      buffer <= '0;
      idx    <= '0;
    end else if (load) begin
      buffer <= load_data;
      idx    <= '0;
    end else if (emit && pix_ready) begin
      idx <= last_byte ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_pixel_streamer.sv
// Reads a run of SRAM words, streams them out as pixels, then writes a status word to a mailbox.
module sram_pixel_streamer
  import sram_pixel_streamer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int PIX_W  = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [ADDR_W-1:0] mailbox_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [3:0]        sram_byteenable,
  output logic [DATA_W-1:0] sram_writedata,
  input  logic [DATA_W-1:0] sram_readdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic [2:0]        fsm_state
);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] mbox_q;
  logic [ADDR_W:0]   word_idx;
  logic              last_word;
  logic              last_accept;
  logic [DATA_W-1:0] status_word;

  assign last_word = (word_idx + 1'b1 == count_q);
  assign fsm_state = state;

  always_comb begin
    status_word                   = '0;
    status_word[STATUS_VALID_BIT] = 1'b1;
    status_word[ADDR_W:0]         = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      mbox_q   <= '0;
      word_idx <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          base_q   <= base_addr;
          count_q  <= word_count;
          mbox_q   <= mailbox_addr;
          word_idx <= '0;
          state    <= (word_count != '0) ? S_RD_REQ : S_WR_STAT;
        end
        S_RD_REQ: state <= S_RD_CAP;
        S_RD_CAP: state <= S_EMIT;
        S_EMIT: if (last_accept) begin
          word_idx <= word_idx + 1'b1;
          state    <= last_word ? S_WR_STAT : S_RD_REQ;
        end
        S_WR_STAT: state <= S_DONE;
        S_DONE:    state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // SRAM port is only driven in the two access states; it idles at all-zero otherwise.
  always_comb begin
    busy            = (state != S_IDLE);
    done            = (state == S_DONE);
    sram_address    = '0;
    sram_chipselect = 1'b0;
    sram_write      = 1'b0;
    sram_byteenable = 4'h0;
    sram_writedata  = '0;
    if (state == S_RD_REQ) begin
      sram_chipselect = 1'b1;
      sram_byteenable = 4'hF;
      sram_address    = base_q + word_idx[ADDR_W-1:0];
    end else if (state == S_WR_STAT) begin
      sram_chipselect = 1'b1;
      sram_write      = 1'b1;
      sram_byteenable = 4'hF;
      sram_address    = mbox_q;
      sram_writedata  = status_word;
    end
  end

  word_unpacker #(
    .DATA_W(DATA_W),
    .PIX_W (PIX_W)
  ) u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .load       (state == S_RD_CAP),
    .load_data  (sram_readdata),
    .emit       (state == S_EMIT),
    .last_word  (last_word),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .last_accept(last_accept)
  );

endmodule

// File: tb/tb_sram_pixel_streamer.sv
// Scoreboard bench for sram_pixel_streamer: SRAM model, pixel/read/write expectation queues.
module tb_sram_pixel_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  word_count;
  logic [7:0]  mailbox_addr;
  logic        busy, done;
  logic [7:0]  sram_address;
  logic        sram_chipselect, sram_write;
  logic [3:0]  sram_byteenable;
  logic [31:0] sram_writedata;
  logic [31:0] sram_readdata;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_ready, pix_last;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  sram_pixel_streamer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .mailbox_addr   (mailbox_addr),
    .busy           (busy),
    .done           (done),
    .sram_address   (sram_address),
    .sram_chipselect(sram_chipselect),
    .sram_write     (sram_write),
    .sram_byteenable(sram_byteenable),
    .sram_writedata (sram_writedata),
    .sram_readdata  (sram_readdata),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_last       (pix_last),
    .fsm_state      (fsm_state)
  );

  // SRAM model: read data one cycle after the address, garbage when not reading.
  logic [31:0] mem  [256];
  logic [31:0] wmem [256];
  int          n_writes = 0;

  always @(posedge clk) begin
    if (sram_chipselect && !sram_write) sram_readdata <= mem[sram_address];
    else                                sram_readdata <= 32'hDEADBEEF;
    if (sram_chipselect && sram_write) begin
      wmem[sram_address] <= sram_writedata;
      n_writes <= n_writes + 1;
    end
  end

  logic [8:0]  exp_q[$];
  logic [7:0]  exp_addr_q[$];
  logic [39:0] exp_wr_q[$];
  int n_cmp = 0, n_err = 0, n_done = 0;
  int ready_mode = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = ~pix_ready;
        default: pix_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: pops expectations as the DUT produces reads, writes and pixels.
  logic       stall_q = 1'b0;
  logic [8:0] held;
  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && pix_valid) check("stall_hold", {pix_last, pix_data}, held);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) check("unexpected_pixel", pix_valid, 0);
        else check("pixel", {pix_last, pix_data}, exp_q.pop_front());
      end
      if (sram_chipselect) check("byteenable", sram_byteenable, 4'hF);
      if (sram_chipselect && !sram_write) begin
        if (exp_addr_q.size() == 0) check("unexpected_read", sram_chipselect, 0);
        else check("read_addr", sram_address, exp_addr_q.pop_front());
      end
      if (sram_chipselect && sram_write) begin
        if (exp_wr_q.size() == 0) check("unexpected_write", sram_write, 0);
        else check("status_write", {sram_address, sram_writedata}, exp_wr_q.pop_front());
      end
      if (done) n_done++;
      stall_q = pix_valid && !pix_ready;
      held    = {pix_last, pix_data};
    end
  end

  function automatic logic [63:0] all_outputs();
    return {6'd0, busy, done, pix_valid, pix_last, sram_chipselect, sram_write,
            sram_address, sram_byteenable, sram_writedata, pix_data};
  endfunction

  task automatic push_expect(input logic [7:0] b, input logic [8:0] cnt, input logic [7:0] mb,
                             output logic [31:0] st);
    logic [7:0] a;
    for (int w = 0; w < int'(cnt); w++) begin
      a = b + w[7:0];
      exp_addr_q.push_back(a);
      for (int k = 0; k < 4; k++)
        exp_q.push_back({(w == int'(cnt) - 1) && (k == 3), mem[a][8*k +: 8]});
    end
    st = 32'h8000_0000 | {23'd0, cnt};
    exp_wr_q.push_back({mb, st});
  endtask

  task automatic drive_start(input logic [7:0] b, input logic [8:0] cnt, input logic [7:0] mb);
    @(negedge clk);
    start = 1'b1; base_addr = b; word_count = cnt; mailbox_addr = mb;
    @(negedge clk);
    start = 1'b0;
    base_addr = 8'($urandom); word_count = 9'($urandom); mailbox_addr = 8'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_xfer(input logic [7:0] b, input logic [8:0] cnt, input logic [7:0] mb,
                          input int glitch_at, input bit check_cycles);
    int          cyc;
    logic [31:0] st;
    push_expect(b, cnt, mb, st);
    drive_start(b, cnt, mb);
    cyc = 1;
    while (!done && cyc < 48 * int'(cnt) + 40) begin
      if (cyc == glitch_at) begin
        start = 1'b1; base_addr = 8'($urandom); word_count = 9'($urandom_range(1, 9));
        mailbox_addr = 8'($urandom);
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    if (check_cycles) check("latency", cyc, 6 * int'(cnt) + 2);
    @(negedge clk);
    check("done_width", done, 0);
    check("busy_after_done", busy, 0);
    check("mailbox", wmem[mb], st);
    check("pixels_left", exp_q.size(), 0);
    check("reads_left", exp_addr_q.size(), 0);
  endtask

  initial begin
    int          writes0, done0;
    logic [31:0] st;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; mailbox_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'h10] = 32'h0403_0201;
    mem[8'h11] = 32'h0807_0605;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;

    run_xfer(8'h10, 9'd2, 8'h40, 0, 1);
    ready_mode = 1;
    run_xfer(8'h10, 9'd2, 8'h41, 0, 0);
    ready_mode = 0;
    run_xfer(8'hFE, 9'd4, 8'h42, 0, 1);
    run_xfer(8'h33, 9'd0, 8'h43, 0, 1);
    run_xfer(8'h50, 9'd3, 8'h44, 5, 1);
    run_xfer(8'h00, 9'd256, 8'h70, 0, 1);

    // Abandon a transfer mid-stream: reset while emitting word 1 of 3.
    wmem[8'h60] = 32'h0;
    push_expect(8'h20, 9'd3, 8'h60, st);
    drive_start(8'h20, 9'd3, 8'h60);
    repeat (9) @(negedge clk);
    check("emit_word1", pix_valid, 1);
    writes0 = n_writes;
    done0   = n_done;
    reset   = 1'b1;
    @(negedge clk);
    check("reset_mid_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    exp_q.delete(); exp_addr_q.delete(); exp_wr_q.delete();
    repeat (10) @(negedge clk);
    check("no_status_write", n_writes, writes0);
    check("no_done_pulse", n_done, done0);
    check("idle_after_reset", busy, 0);
    run_xfer(8'h20, 9'd3, 8'h61, 0, 1);

    ready_mode = 2;
    for (int i = 0; i < 4; i++)
      run_xfer(8'($urandom_range(0, 255)), 9'($urandom_range(1, 6)), 8'h80 + 8'(i), 7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
